// File: rtl/key_vault_pkg.sv
// Shared types and default constants for the key vault sentinel.
// ST_TAMPER exists only when KEY_INTEGRITY_EN is defined.
package key_vault_pkg;

    localparam int unsigned DEF_KEY_WIDTH      = 8;
    localparam logic [7:0]  DEF_KEY_VALUE      = 8'hB6;
    localparam logic [7:0]  DEF_INV_MASK       = 8'h55;
    localparam int unsigned DEF_MAX_FAILS      = 3;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_GRANTED = 3'd2,
`ifdef KEY_INTEGRITY_EN
        ST_LOCKOUT = 3'd3,
        ST_TAMPER  = 3'd4
`else
        ST_LOCKOUT = 3'd3
`endif
    } vault_state_e;

    // Width of a down-counter that must hold n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_bit_cell.sv
// One key bit held in its own flop, optionally stored inverted.
// bit_out is the reconstructed logical key bit.
(* keep_hierarchy = "yes" *)
module key_bit_cell #(
    parameter logic KEY_BIT = 1'b0,
    parameter logic INVERT  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    output logic bit_out
);

    logic cell_q;

    // The cell only ever reloads itself; its content comes from reset alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_q <= KEY_BIT ^ INVERT;
        end else begin
            cell_q <= cell_q;
        end
    end

    assign bit_out = cell_q ^ INVERT;

endmodule

// File: rtl/key_vault_sentinel.sv
// Key comparator with scattered key storage, registered results and a timed
// lockout after repeated failures. Define KEY_INTEGRITY_EN for a shadow bank
// and a sticky TAMPER state.
module key_vault_sentinel
    import key_vault_pkg::*;
#(
    parameter int unsigned           KEY_WIDTH      = DEF_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0]  KEY_VALUE      = KEY_WIDTH'(DEF_KEY_VALUE),
    parameter logic [KEY_WIDTH-1:0]  INV_MASK       = KEY_WIDTH'(DEF_INV_MASK),
    parameter int unsigned           MAX_FAILS      = DEF_MAX_FAILS,
    parameter int unsigned           LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    localparam int unsigned          FC_W           = $clog2(MAX_FAILS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_valid,
    input  logic [KEY_WIDTH-1:0] key_data,
    output logic                 key_ready,
    input  logic                 deauth,
    output logic                 is_authorized,
    output logic                 auth_ok,
    output logic                 auth_fail,
    output logic                 locked,
    output logic [FC_W-1:0]      fail_count
);

    localparam int unsigned   LC_W      = cnt_width(LOCKOUT_CYCLES);
    localparam logic [LC_W-1:0] LOCK_LOAD = LC_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FC_W-1:0] FAIL_MAX  = FC_W'(MAX_FAILS);

    vault_state_e         state_q, state_d;
    logic [KEY_WIDTH-1:0] cand_q, cand_d;
    logic [FC_W-1:0]      fail_q, fail_d;
    logic [FC_W-1:0]      fail_inc;
    logic [LC_W-1:0]      lock_cnt_q, lock_cnt_d;
    logic                 ok_q, ok_d;
    logic                 fail_pulse_q, fail_pulse_d;

    logic [KEY_WIDTH-1:0] key_rec;
    logic                 accept;
    logic                 match;

    for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_primary
        key_bit_cell #(
            .KEY_BIT (KEY_VALUE[i]),
            .INVERT  (INV_MASK[i])
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .bit_out (key_rec[i])
        );
    end

`ifdef KEY_INTEGRITY_EN
    logic [KEY_WIDTH-1:0] key_shadow;
    logic                 tamper;

    // Complementary encoding: a single upset cell cannot hit both banks alike.
    for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_shadow
        key_bit_cell #(
            .KEY_BIT (KEY_VALUE[i]),
            .INVERT  (~INV_MASK[i])
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .bit_out (key_shadow[i])
        );
    end

    assign tamper = |(key_rec ^ key_shadow);
`endif

    // Full-width reduction with no early exit keeps timing data-independent.
    assign match     = ~|(cand_q ^ key_rec);
    assign key_ready = (state_q == ST_IDLE) | ((state_q == ST_GRANTED) & ~deauth);
    assign accept    = key_valid & key_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        fail_d       = fail_q;
        lock_cnt_d   = lock_cnt_q;
        ok_d         = 1'b0;
        fail_pulse_d = 1'b0;
        fail_inc     = (fail_q >= FAIL_MAX) ? fail_q : fail_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cand_d  = key_data;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (match) begin
                    ok_d    = 1'b1;
                    fail_d  = '0;
                    state_d = ST_GRANTED;
                end else begin
                    fail_pulse_d = 1'b1;
                    fail_d       = fail_inc;
                    if (fail_inc == FAIL_MAX) begin
                        lock_cnt_d = LOCK_LOAD;
                        state_d    = ST_LOCKOUT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GRANTED: begin
                if (deauth) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    cand_d  = key_data;
                    state_d = ST_CHECK;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == '0) begin
                    fail_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
            end
`ifdef KEY_INTEGRITY_EN
            ST_TAMPER: begin
                state_d = ST_TAMPER;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef KEY_INTEGRITY_EN
        if (tamper) begin
            state_d      = ST_TAMPER;
            ok_d         = 1'b0;
            fail_pulse_d = 1'b0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cand_q       <= '0;
            fail_q       <= '0;
            lock_cnt_q   <= '0;
            ok_q         <= 1'b0;
            fail_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            fail_q       <= fail_d;
            lock_cnt_q   <= lock_cnt_d;
            ok_q         <= ok_d;
            fail_pulse_q <= fail_pulse_d;
        end
    end

    assign is_authorized = (state_q == ST_GRANTED);
    assign auth_ok       = ok_q;
    assign auth_fail     = fail_pulse_q;
    assign fail_count    = fail_q;
`ifdef KEY_INTEGRITY_EN
    assign locked        = (state_q == ST_LOCKOUT) | (state_q == ST_TAMPER);
`else
    assign locked        = (state_q == ST_LOCKOUT);
`endif

endmodule

// File: tb/tb_key_vault_sentinel.sv
// Scoreboard bench for key_vault_sentinel with default parameters.
// Tamper checks run only when KEY_INTEGRITY_EN is defined.
module tb_key_vault_sentinel;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_data  = 8'h00;
    logic       deauth    = 1'b0;
    logic       key_ready;
    logic       is_authorized;
    logic       auth_ok;
    logic       auth_fail;
    logic       locked;
    logic [1:0] fail_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic       ok;
        logic       fail;
        logic [1:0] fc;
        logic       auth;
        logic       lock;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    key_vault_sentinel dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_data      (key_data),
        .key_ready     (key_ready),
        .deauth        (deauth),
        .is_authorized (is_authorized),
        .auth_ok       (auth_ok),
        .auth_fail     (auth_fail),
        .locked        (locked),
        .fail_count    (fail_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (auth_ok || auth_fail)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, auth_ok, auth_fail}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("auth_ok",       auth_ok,       mon_e.ok);
                check("auth_fail",     auth_fail,     mon_e.fail);
                check("fail_count",    fail_count,    mon_e.fc);
                check("is_authorized", is_authorized, mon_e.auth);
                check("locked",        locked,        mon_e.lock);
                check("latency",       cyc,           mon_e.at);
            end
        end
    end

    task automatic send_key(input logic [7:0] k, input logic e_ok, input logic [1:0] e_fc,
                            input logic e_auth, input logic e_lock);
        int w = 0;
        @(negedge clk);
        while (!key_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!key_ready) begin
            check("ready_timeout", key_ready, 1);
            return;
        end
        key_valid = 1'b1;
        key_data  = k;
        sb.push_back('{e_ok, !e_ok, e_fc, e_auth, e_lock, cyc + 2});
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("sb_drain", sb.size(), 0);
    endtask

    initial begin
        int lock_cycles;
        int ready_bad;

        // Reset state.
        #12;
        check("rst_key_ready",     key_ready,     1);
        check("rst_is_authorized", is_authorized, 0);
        check("rst_auth_ok",       auth_ok,       0);
        check("rst_auth_fail",     auth_fail,     0);
        check("rst_locked",        locked,        0);
        check("rst_fail_count",    fail_count,    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Correct key.
        send_key(8'hB6, 1'b1, 2'd0, 1'b1, 1'b0);
        drain();
        check("granted_level", is_authorized, 1);

        // deauth wins over a simultaneous key.
        @(negedge clk);
        key_valid = 1'b1;
        key_data  = 8'hB6;
        deauth    = 1'b1;
        #1;
        check("deauth_ready_low", key_ready, 0);
        @(negedge clk);
        key_valid = 1'b0;
        deauth    = 1'b0;
        check("deauth_revoked", is_authorized, 0);
        check("deauth_idle_ready", key_ready, 1);
        repeat (3) @(negedge clk);
        check("deauth_no_pending", sb.size(), 0);

        // Failed re-attempt from GRANTED revokes authorization.
        send_key(8'hB6, 1'b1, 2'd0, 1'b1, 1'b0);
        send_key(8'hB7, 1'b0, 2'd1, 1'b0, 1'b0);
        drain();
        check("reattempt_fc", fail_count, 1);

        // Match clears the counter, then three wrong keys lock out.
        send_key(8'hB6, 1'b1, 2'd0, 1'b1, 1'b0);
        send_key(8'h00, 1'b0, 2'd1, 1'b0, 1'b0);
        send_key(8'h00, 1'b0, 2'd2, 1'b0, 1'b0);
        send_key(8'h00, 1'b0, 2'd3, 1'b0, 1'b1);
        key_valid   = 1'b1;
        key_data    = 8'hB6;
        lock_cycles = 0;
        ready_bad   = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (locked) begin
                lock_cycles++;
                if (key_ready) ready_bad++;
            end else if (lock_cycles > 0) begin
                break;
            end
            if (lock_cycles == 100) key_valid = 1'b0;
        end
        key_valid = 1'b0;
        check("lockout_length", lock_cycles, 1024);
        check("lockout_ready_low", ready_bad, 0);
        check("post_lock_fc", fail_count, 0);
        check("post_lock_ready", key_ready, 1);
        check("post_lock_sb", sb.size(), 0);

        // Reset during lockout.
        send_key(8'h00, 1'b0, 2'd1, 1'b0, 1'b0);
        send_key(8'h00, 1'b0, 2'd2, 1'b0, 1'b0);
        send_key(8'h00, 1'b0, 2'd3, 1'b0, 1'b1);
        drain();
        repeat (10) @(negedge clk);
        check("mid_lock_locked", locked, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_locked", locked, 0);
        check("rst_mid_fc", fail_count, 0);
        check("rst_mid_ready", key_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        send_key(8'hB6, 1'b1, 2'd0, 1'b1, 1'b0);
        drain();

`ifdef KEY_INTEGRITY_EN
        // Corrupt one shadow cell; the vault must latch into TAMPER.
        @(negedge clk);
        force dut.g_shadow[0].u_cell.cell_q = 1'b1;
        @(negedge clk);
        check("tamper_locked", locked, 1);
        check("tamper_auth", is_authorized, 0);
        check("tamper_ready", key_ready, 0);
        key_valid = 1'b1;
        key_data  = 8'hB6;
        repeat (5) @(negedge clk);
        check("tamper_refuse_ready", key_ready, 0);
        check("tamper_still_locked", locked, 1);
        key_valid = 1'b0;
        release dut.g_shadow[0].u_cell.cell_q;
        @(negedge clk);
        check("tamper_sticky", locked, 1);
        rst_n = 1'b0;
        #1;
        check("tamper_rst_locked", locked, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_key(8'hB6, 1'b1, 2'd0, 1'b1, 1'b0);
        drain();
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_vault_sentinel.md
# key_vault_sentinel

Parametrised successor to the single-byte scattered key comparator. It holds a KEY_WIDTH-bit key in individually instantiated, selectively inverted 1-bit cells and accepts candidate keys over a valid/ready handshake. Results are registered, and repeated failures trigger a timed lockout. It sits between the external key-entry path and the Citadel unlock/enable logic, which consumes `is_authorized`.

## Interface
- `KEY_WIDTH`, 8: key width in bits (≥2).
- `KEY_VALUE`, 8'hB6: logical key value.
- `INV_MASK`, 8'h55: bit=1 means that cell stores the key bit inverted.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 1024: lockout duration in clk cycles (≥1).
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_valid` in 1: candidate key present.
- `key_data` in KEY_WIDTH: candidate key.
- `key_ready` out 1: block can accept a candidate.
- `deauth` in 1: drop authorization (GRANTED only).
- `is_authorized` out 1: level, high in GRANTED.
- `auth_ok` out 1: one-cycle pulse on match.
- `auth_fail` out 1: one-cycle pulse on mismatch.
- `locked` out 1: high in LOCKOUT.
- `fail_count` out $clog2(MAX_FAILS+1): consecutive failures so far.

## Operation
- **Storage.** KEY_WIDTH separate 1-bit cells. Cell i resets to KEY_VALUE[i]^INV_MASK[i] and holds that value thereafter. Reconstructed key = cells ^ INV_MASK.
- **States.** IDLE, CHECK, GRANTED, LOCKOUT (plus TAMPER when KEY_INTEGRITY_EN is defined).
- **Ready.** `key_ready` = (IDLE) | (GRANTED & !deauth). It is combinational from state and deauth only, never from key_valid.
- **Accept.** A key is accepted when key_valid & key_ready. key_data is captured into a candidate register and the FSM moves to CHECK.
- **CHECK.** Full-width compare of the candidate against the reconstructed key (no early exit). Then:
  - Match: auth_ok pulse, fail_count←0, go to GRANTED.
  - Mismatch: auth_fail pulse, fail_count+1. If the new count equals MAX_FAILS, go to LOCKOUT and load the lockout counter with LOCKOUT_CYCLES-1. Otherwise go to IDLE (a failed re-attempt from GRANTED also revokes authorization).
- **GRANTED.**
  - deauth=1: go to IDLE next cycle. deauth takes priority over a simultaneous key_valid, and that key is not accepted.
  - deauth in any other state is ignored.
- **LOCKOUT.**
  - key_ready=0 and locked=1.
  - The counter decrements each cycle. When it reaches 0: fail_count←0, go to IDLE.
  - key_valid during lockout is ignored; no pulses are generated.
- **Saturation.** fail_count never exceeds MAX_FAILS.

## Timing
- **Reset values.**
  - All outputs 0 except key_ready=1 (IDLE). fail_count=0.
  - Candidate register 0; cells at their encoded values.
- **Result latency.** Handshake in cycle N → CHECK in N+1. auth_ok/auth_fail are registered and high in N+2. is_authorized/locked change in N+2. key_ready is high again in N+2 (IDLE/GRANTED).
- **Throughput.** At most one attempt per 2 cycles.
- **Lockout length.** locked is high for exactly LOCKOUT_CYCLES cycles, starting at N+2.
- **Reset mid-operation.** Any state (including mid-lockout) returns to IDLE immediately. Lockout is not persistent across reset.

## Configuration
- **KEY_INTEGRITY_EN defined.**
  - A second cell bank stores the key with mask ~INV_MASK.
  - Both reconstructions are compared every cycle. Any mismatch moves the FSM to TAMPER on the next edge, from any state.
  - TAMPER: key_ready=0, is_authorized=0, locked=1, no pulses. Only rst_n exits it.
- **KEY_INTEGRITY_EN undefined.** Single bank only; the TAMPER state and its logic are absent.

## Structure
- **Package `key_vault_pkg`:** the FSM state enum typedef, and default constants for KEY_WIDTH, KEY_VALUE, INV_MASK, MAX_FAILS and LOCKOUT_CYCLES.
- **Sub-module `key_bit_cell`:**
  - Parameters KEY_BIT and INVERT.
  - Ports clk, rst_n, bit_out (reconstructed bit).
  - Marked keep_hierarchy so each cell stays a distinct, placeable flop.
  - Instantiated per bit via generate (and again for the shadow bank).

## Test plan
- **Match (reset, defaults).** Send 8'hB6 → auth_ok at N+2, is_authorized=1, fail_count=0.
- **Lockout entry.** Send 8'h00 three times → auth_fail ×3, fail_count 1,2,3. locked=1 for exactly 1024 cycles, key_ready=0, an attempt with key_valid held high during lockout is ignored. Afterwards fail_count=0 and key_ready=1.
- **Deauth priority.** In GRANTED, deauth=1 with key_valid=1, key 8'hB6 → key not accepted, IDLE next cycle, is_authorized=0, no pulse.
- **Failed re-attempt.** In GRANTED, send 8'hB7 → auth_fail, is_authorized=0 at N+2, fail_count=1.
- **Reset mid-lockout.** Assert rst_n=0 during locked=1 → immediately locked=0, fail_count=0, key_ready=1.
- **Tamper (KEY_INTEGRITY_EN).** Force one shadow cell to flip → locked=1, is_authorized=0, and 8'hB6 is refused until reset.
